shift_add_multiplier: RTL and testbench

Sequential signed shift-add multiplier datapath. It is driven by the multiplier control FSM: `load_data` captures operands, and `shift_en` advances one partial-product step per cycle. It returns a one-cycle `mult_done` pulse and holds the signed product for the seven-segment display path. Operands are converted to sign-magnitude, multiplied unsigned over WIDTH steps, and the sign is re-applied in a final step.

---
 rtl/shift_add_multiplier_if.sv | 24 ++
 rtl/shift_add_multiplier.sv | 109 ++++++++++
 tb/tb_shift_add_multiplier.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// Operand/control/result bundle between the multiplier control FSM (master)
// and the shift-add multiplier datapath (slave).
interface shift_add_multiplier_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 load_data;
   logic                 shift_en;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic [2*WIDTH-1:0]   product;
   logic                 negative;
   logic                 mult_done;
   logic                 busy;

   modport master (
      output load_data, shift_en, multiplicand, multiplier,
      input  product, negative, mult_done, busy
   );

   modport slave (
      input  load_data, shift_en, multiplicand, multiplier,
      output product, negative, mult_done, busy
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential signed shift-add multiplier: sign-magnitude operands, WIDTH unsigned
// add/shift steps gated by shift_en, then one cycle to re-apply the sign.
module shift_add_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   shift_add_multiplier_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mag_b_q, mag_b_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 sign_q, sign_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 negative_q, negative_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic                 neg_res;

   // |x| as WIDTH-bit unsigned: the most negative value maps to 2^(WIDTH-1)
   assign mag_a   = bus.multiplicand[WIDTH-1] ? ('0 - bus.multiplicand) : bus.multiplicand;
   assign mag_b   = bus.multiplier[WIDTH-1]   ? ('0 - bus.multiplier)   : bus.multiplier;
   assign neg_res = sign_q && (acc_q != '0);

   always_comb begin
      state_d    = state_q;
      mag_b_d    = mag_b_q;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      count_d    = count_q;
      sign_d     = sign_q;
      product_d  = product_q;
      negative_d = negative_q;
      done_d     = 1'b0;

      if (clr) begin
         state_d    = IDLE;
         mag_b_d    = '0;
         mcand_d    = '0;
         acc_d      = '0;
         count_d    = '0;
         sign_d     = 1'b0;
         product_d  = '0;
         negative_d = 1'b0;
      end else if (bus.load_data) begin
         state_d = RUN;
         mag_b_d = mag_b;
         mcand_d = {{WIDTH{1'b0}}, mag_a};
         acc_d   = '0;
         count_d = '0;
         sign_d  = bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
      end else begin
         unique case (state_q)
            RUN: begin
               if (bus.shift_en) begin
                  if (mag_b_q[0]) acc_d = acc_q + mcand_q;
                  mcand_d = mcand_q << 1;
                  mag_b_d = mag_b_q >> 1;
                  count_d = count_q + CW'(1);
                  if (count_q == CW'(WIDTH - 1)) state_d = SIGN;
               end
            end
            SIGN: begin
               product_d  = neg_res ? ('0 - acc_q) : acc_q;
               negative_d = neg_res;
               done_d     = 1'b1;
               state_d    = DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mag_b_q    <= '0;
         mcand_q    <= '0;
         acc_q      <= '0;
         count_q    <= '0;
         sign_q     <= 1'b0;
         product_q  <= '0;
         negative_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mag_b_q    <= mag_b_d;
         mcand_q    <= mcand_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         sign_q     <= sign_d;
         product_q  <= product_d;
         negative_q <= negative_d;
         done_q     <= done_d;
      end
   end

   assign bus.product   = product_q;
   assign bus.negative  = negative_q;
   assign bus.mult_done = done_q;
   assign bus.busy      = (state_q == RUN) || (state_q == SIGN);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases, stalls, restart,
// clear and async reset, plus random operands against an integer-product model.
module tb_shift_add_multiplier;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   logic clr;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [2*W-1:0] last_p = '0;
   logic           last_n = 1'b0;

   shift_add_multiplier_if #(.WIDTH(W)) bus ();

   shift_add_multiplier #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Load a,b then step; shift_en is low for edges stall_start..stall_start+stall_len-1.
   task automatic mult_run(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall_start, input int stall_len);
      logic [2*W-1:0] exp_p;
      int lat;
      exp_p = (2*W)'($signed(a) * $signed(b));
      lat   = W + 1 + stall_len;
      bus.multiplicand = a;
      bus.multiplier   = b;
      bus.load_data    = 1'b1;
      bus.shift_en     = 1'b0;
      tick();
      bus.load_data = 1'b0;
      for (int e = 1; e <= lat + 2; e++) begin
         bus.shift_en = (e >= stall_start && e < stall_start + stall_len) ? 1'b0 : 1'b1;
         tick();
         chk("mult_done", 64'(bus.mult_done), 64'(e == lat));
         chk("busy", 64'(bus.busy), 64'(e < lat));
         if (e < lat) begin
            chk("product_held", 64'(bus.product), 64'(last_p));
            chk("negative_held", 64'(bus.negative), 64'(last_n));
         end else begin
            chk("product", 64'(bus.product), 64'(exp_p));
            chk("negative", 64'(bus.negative), 64'($signed(exp_p) < 0));
         end
      end
      last_p = exp_p;
      last_n = $signed(exp_p) < 0;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      rst = 1'b1;
      clr = 1'b0;
      bus.load_data    = 1'b0;
      bus.shift_en     = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      #12;
      chk("rst_product", 64'(bus.product), 64'd0);
      chk("rst_negative", 64'(bus.negative), 64'd0);
      chk("rst_done", 64'(bus.mult_done), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // IDLE ignores shift_en
      bus.shift_en = 1'b1;
      tick();
      tick();
      chk("idle_busy", 64'(bus.busy), 64'd0);
      chk("idle_done", 64'(bus.mult_done), 64'd0);

      mult_run(8'd5,    8'd3,    0, 0);
      mult_run(8'hF9,   8'd6,    0, 0);
      mult_run(8'd7,    8'hFA,   0, 0);
      mult_run(8'h80,   8'h80,   0, 0);
      mult_run(8'h80,   8'h7F,   0, 0);
      mult_run(8'd0,    8'hFB,   0, 0);
      mult_run(8'hFF,   8'hFF,   0, 0);
      mult_run(8'd12,   8'd11,   5, 3);

      // Restart after four steps: only the second operation completes
      bus.multiplicand = 8'hB3;
      bus.multiplier   = 8'h5D;
      bus.load_data    = 1'b1;
      tick();
      bus.load_data = 1'b0;
      bus.shift_en  = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         chk("abort_done", 64'(bus.mult_done), 64'd0);
         chk("abort_busy", 64'(bus.busy), 64'd1);
      end
      mult_run(8'd2, 8'd3, 0, 0);

      for (int i = 0; i < 25; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 3 == 0) mult_run(ra, rb, int'($urandom_range(W, 1)), int'($urandom_range(4, 1)));
         else            mult_run(ra, rb, 0, 0);
      end

      // clr coincident with load_data wins
      mult_run(8'd9, 8'd9, 0, 0);
      bus.multiplicand = 8'd4;
      bus.multiplier   = 8'd4;
      bus.load_data    = 1'b1;
      clr              = 1'b1;
      tick();
      bus.load_data = 1'b0;
      clr           = 1'b0;
      last_p = '0;
      last_n = 1'b0;
      chk("clr_product", 64'(bus.product), 64'd0);
      chk("clr_busy", 64'(bus.busy), 64'd0);
      for (int e = 0; e < W + 3; e++) begin
         tick();
         chk("clr_no_done", 64'(bus.mult_done), 64'd0);
      end

      // Async reset mid-RUN
      mult_run(8'hF9, 8'd6, 0, 0);
      bus.multiplicand = 8'd10;
      bus.multiplier   = 8'd10;
      bus.load_data    = 1'b1;
      tick();
      bus.load_data = 1'b0;
      for (int e = 0; e < 3; e++) tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_product", 64'(bus.product), 64'd0);
      chk("arst_negative", 64'(bus.negative), 64'd0);
      chk("arst_busy", 64'(bus.busy), 64'd0);
      #1 rst = 1'b0;
      for (int e = 0; e < W + 3; e++) begin
         tick();
         chk("arst_no_done", 64'(bus.mult_done), 64'd0);
         chk("arst_idle_busy", 64'(bus.busy), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
